// File: rtl/int_top_reg_host_disp.sv
// rtl/int_top_reg_host_disp.sv - host-side word-guess game core driving two LCD rows and indicator LEDs
// Optional macro HOST_DISP_REPEAT_DETECT_EN: repeated letters light blue with no penalty.
module int_top_reg_host_disp #(
  parameter int LED_HOLD = 10000,
  parameter int MAX_MISS = 6
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [39:0]  setWord,
  input  logic         toggle_state,
  input  logic [7:0]   msg,
  input  logic         ready,
  input  logic         rec_ready,
  input  logic         gameEnd_host,
  output logic [127:0] host_row1,
  output logic [127:0] host_row2,
  output logic         green,
  output logic         red,
  output logic         blue,
  output logic         err_LED
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;
  localparam logic [1:0] S_LOSE = 2'd3;
  localparam int HW = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LED_HOLD - 1);
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic [1:0]    state_q, state_d;
  logic [39:0]   word_q, word_d;
  logic [4:0]    reveal_q, reveal_d;
  logic [3:0]    miss_cnt_q, miss_cnt_d;
  logic [47:0]   miss_list_q, miss_list_d;
  logic          ready_prev_q, ready_prev_d;
  logic          pend_q, pend_d;
  logic [7:0]    msg_q, msg_d;
  logic [3:0]    led_q, led_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [127:0]  row1_q, row1_d, row2_q, row2_d;
  logic [4:0]    hit;
  logic          is_letter, is_repeat;
`ifdef HOST_DISP_REPEAT_DETECT_EN
  logic [31:0]   guessed_q, guessed_d;
  logic [4:0]    letter_idx;
`endif

  always_comb begin
    ready_prev_d = ready;
    msg_d        = msg;
    // Guess is captured on the ready edge; it is evaluated one cycle later.
    pend_d       = ready & ~ready_prev_q & rec_ready & (state_q == S_PLAY);
    state_d      = state_q;
    word_d       = word_q;
    reveal_d     = reveal_q;
    miss_cnt_d   = miss_cnt_q;
    miss_list_d  = miss_list_q;
    led_d        = led_q;
    hold_d       = hold_q;
    is_letter    = (msg_q >= 8'h41) && (msg_q <= 8'h5A);
    for (int i = 0; i < 5; i++) hit[i] = (word_q[39-8*i -: 8] == msg_q);
`ifdef HOST_DISP_REPEAT_DETECT_EN
    guessed_d    = guessed_q;
    letter_idx   = 5'(msg_q - 8'h41);
    is_repeat    = guessed_q[letter_idx];
`else
    is_repeat    = 1'b0;
`endif

    if (hold_q != '0) hold_d = hold_q - HW'(1);
    else              led_d  = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (toggle_state) begin
          word_d      = setWord;
          reveal_d    = 5'b0;
          miss_cnt_d  = 4'd0;
          miss_list_d = {6{8'h20}};
`ifdef HOST_DISP_REPEAT_DETECT_EN
          guessed_d   = 32'b0;
`endif
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        if (gameEnd_host) begin
          state_d = S_IDLE;
        end else if (pend_q) begin
          hold_d = HOLD_LOAD;
          if (!is_letter) begin
            led_d = 4'b1000;
          end else if (is_repeat) begin
            led_d = 4'b0100;
          end else begin
`ifdef HOST_DISP_REPEAT_DETECT_EN
            guessed_d[letter_idx] = 1'b1;
`endif
            if (|hit) begin
              led_d    = 4'b0010;
              reveal_d = reveal_q | hit;
              if (reveal_d == 5'h1F) state_d = S_WIN;
            end else begin
              led_d = 4'b0001;
              for (int i = 0; i < 6; i++)
                if (miss_cnt_q == 4'(i)) miss_list_d[47-8*i -: 8] = msg_q;
              miss_cnt_d = miss_cnt_q + 4'd1;
              if (miss_cnt_d == 4'(MAX_MISS)) state_d = S_LOSE;
            end
          end
        end
      end
      default: begin
        if (gameEnd_host) state_d = S_IDLE;
      end
    endcase

    row1_d = BLANK;
    row2_d = BLANK;
    case (state_d)
      S_PLAY: begin
        for (int i = 0; i < 5; i++)
          row1_d[127-8*i -: 8] = reveal_d[i] ? word_d[39-8*i -: 8] : 8'h5F;
        row2_d[127:80] = miss_list_d;
        row2_d[7:0]    = 8'h30 + {4'b0, miss_cnt_d};
      end
      S_WIN: begin
        row1_d[127:88]  = word_d;
        row2_d[127:104] = 24'h57494E;
      end
      S_LOSE: begin
        row1_d[127:88] = word_d;
        row2_d[127:96] = 32'h4C4F5345;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= S_IDLE;
      word_q       <= 40'b0;
      reveal_q     <= 5'b0;
      miss_cnt_q   <= 4'd0;
      miss_list_q  <= {6{8'h20}};
      ready_prev_q <= 1'b0;
      pend_q       <= 1'b0;
      msg_q        <= 8'h00;
      led_q        <= 4'b0;
      hold_q       <= '0;
      row1_q       <= BLANK;
      row2_q       <= BLANK;
`ifdef HOST_DISP_REPEAT_DETECT_EN
      guessed_q    <= 32'b0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      reveal_q     <= reveal_d;
      miss_cnt_q   <= miss_cnt_d;
      miss_list_q  <= miss_list_d;
      ready_prev_q <= ready_prev_d;
      pend_q       <= pend_d;
      msg_q        <= msg_d;
      led_q        <= led_d;
      hold_q       <= hold_d;
      row1_q       <= row1_d;
      row2_q       <= row2_d;
`ifdef HOST_DISP_REPEAT_DETECT_EN
      guessed_q    <= guessed_d;
`endif
    end
  end

  assign host_row1 = row1_q;
  assign host_row2 = row2_q;
  assign err_LED   = led_q[3];
  assign blue      = led_q[2];
  assign green     = led_q[1];
  assign red       = led_q[0];

endmodule

// File: tb/tb_int_top_reg_host_disp.sv
// tb/tb_int_top_reg_host_disp.sv - table-driven and randomized bench for int_top_reg_host_disp
module tb_int_top_reg_host_disp;
  localparam int LED_HOLD = 16;
  localparam int MAX_MISS = 6;
`ifdef HOST_DISP_REPEAT_DETECT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam logic [127:0] BLANK = {16{8'h20}};
  localparam logic [3:0] L_ERR = 4'b1000, L_BLUE = 4'b0100, L_GREEN = 4'b0010, L_RED = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nRst, toggle_state, ready, rec_ready, gameEnd_host;
  logic [39:0]  setWord;
  logic [7:0]   msg;
  logic [127:0] host_row1, host_row2;
  logic         green, red, blue, err_LED;
  logic [3:0]   leds_act;
  assign leds_act = {err_LED, blue, green, red};

  int_top_reg_host_disp #(.LED_HOLD(LED_HOLD), .MAX_MISS(MAX_MISS)) dut (
    .clk(clk), .nRst(nRst), .setWord(setWord), .toggle_state(toggle_state),
    .msg(msg), .ready(ready), .rec_ready(rec_ready), .gameEnd_host(gameEnd_host),
    .host_row1(host_row1), .host_row2(host_row2),
    .green(green), .red(red), .blue(blue), .err_LED(err_LED)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: 0 idle, 1 play, 2 win, 3 lose
  int         m_state;
  logic [7:0] m_word [5];
  bit         m_rev [5];
  bit         m_seen [26];
  logic [7:0] m_miss [$];
  logic [3:0] m_leds;

  function automatic logic [127:0] s2row(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [39:0] s2word(input string s);
    logic [39:0] w;
    for (int i = 0; i < 5; i++) w[39-8*i -: 8] = s[i];
    return w;
  endfunction

  function automatic logic [127:0] p2(input string misses, input int n);
    logic [127:0] r;
    r = s2row(misses);
    r[7:0] = 8'h30 + 8'(n);
    return r;
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_leds  = 4'b0;
    m_miss.delete();
  endfunction

  function automatic void model_start(input logic [39:0] w);
    if (m_state != 0) return;
    m_state = 1;
    for (int i = 0; i < 5; i++) begin
      m_word[i] = w[39-8*i -: 8];
      m_rev[i]  = 1'b0;
    end
    for (int i = 0; i < 26; i++) m_seen[i] = 1'b0;
    m_miss.delete();
  endfunction

  function automatic void model_guess(input logic [7:0] c);
    bit hit, all;
    if (m_state != 1) return;
    if (c < 8'h41 || c > 8'h5A) begin
      m_leds = L_ERR;
      return;
    end
    if (REP && m_seen[c - 8'h41]) begin
      m_leds = L_BLUE;
      return;
    end
    m_seen[c - 8'h41] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) if (m_word[i] == c) begin m_rev[i] = 1'b1; hit = 1'b1; end
    if (hit) begin
      m_leds = L_GREEN;
      all = 1'b1;
      for (int i = 0; i < 5; i++) all = all & m_rev[i];
      if (all) m_state = 2;
    end else begin
      m_leds = L_RED;
      m_miss.push_back(c);
      if (m_miss.size() == MAX_MISS) m_state = 3;
    end
  endfunction

  function automatic logic [127:0] exp_row1();
    logic [127:0] r = BLANK;
    if (m_state != 0)
      for (int i = 0; i < 5; i++)
        r[127-8*i -: 8] = (m_state == 1 && !m_rev[i]) ? 8'h5F : m_word[i];
    return r;
  endfunction

  function automatic logic [127:0] exp_row2();
    logic [127:0] r = BLANK;
    if (m_state == 1) begin
      for (int i = 0; i < m_miss.size() && i < 6; i++) r[127-8*i -: 8] = m_miss[i];
      r[7:0] = 8'h30 + 8'(m_miss.size());
    end else if (m_state == 2) r = s2row("WIN");
    else if (m_state == 3) r = s2row("LOSE");
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, " row1"}, host_row1, exp_row1());
    chk({nm, " row2"}, host_row2, exp_row2());
    chk({nm, " leds"}, {124'b0, leds_act}, {124'b0, m_leds});
  endtask

  task automatic do_guess(input logic [7:0] c);
    @(negedge clk); msg = c; ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    model_guess(c);
  endtask

  task automatic start_game(input logic [39:0] w);
    @(negedge clk); setWord = w; toggle_state = 1'b1;
    @(negedge clk); toggle_state = 1'b0; setWord = {$urandom, 8'($urandom)};
    @(negedge clk);
    model_start(w);
  endtask

  task automatic end_game();
    @(negedge clk); gameEnd_host = 1'b1;
    @(negedge clk); gameEnd_host = 1'b0;
    @(negedge clk);
    m_state = 0;
  endtask

  typedef struct {
    int           kind;   // 0 guess, 1 start, 2 end
    logic [39:0]  word;
    logic [7:0]   ch;
    logic [3:0]   leds;
    logic [127:0] r1;
    logic [127:0] r2;
  } vec_t;

  function automatic vec_t mk(input int k, input string w, input logic [7:0] c,
                              input logic [3:0] l, input logic [127:0] r1, input logic [127:0] r2);
    vec_t v;
    v.kind = k; v.word = (k == 1) ? s2word(w) : 40'b0; v.ch = c;
    v.leds = l; v.r1 = r1; v.r2 = r2;
    return v;
  endfunction

  vec_t tbl [16];
  logic [39:0] rw;
  logic [7:0]  rc;

  initial begin
    nRst = 1'b0; setWord = 40'b0; toggle_state = 1'b0; msg = 8'h00;
    ready = 1'b0; rec_ready = 1'b1; gameEnd_host = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset row1", host_row1, BLANK);
    chk("reset row2", host_row2, BLANK);
    chk("reset leds", {124'b0, leds_act}, 128'b0);
    nRst = 1'b1;

    do_guess("A");
    check_model("idle ready");

    tbl[0]  = mk(1, "MOORE", 8'h00, 4'b0,    s2row("_____"), p2("", 0));
    tbl[1]  = mk(0, "", "O", L_GREEN, s2row("_OO__"), p2("", 0));
    tbl[2]  = mk(0, "", "P", L_RED,   s2row("_OO__"), p2("P", 1));
    tbl[3]  = mk(0, "", "M", L_GREEN, s2row("MOO__"), p2("P", 1));
    tbl[4]  = mk(0, "", "M", REP ? L_BLUE : L_GREEN, s2row("MOO__"), p2("P", 1));
    tbl[5]  = mk(0, "", "R", L_GREEN, s2row("MOOR_"), p2("P", 1));
    tbl[6]  = mk(0, "", "E", L_GREEN, s2row("MOORE"), s2row("WIN"));
    tbl[7]  = mk(2, "", 8'h00, L_GREEN, BLANK, BLANK);
    tbl[8]  = mk(1, "YUMMY", 8'h00, L_GREEN, s2row("_____"), p2("", 0));
    tbl[9]  = mk(0, "", "I", L_RED, s2row("_____"), p2("I", 1));
    tbl[10] = mk(0, "", "L", L_RED, s2row("_____"), p2("IL", 2));
    tbl[11] = mk(0, "", "K", L_RED, s2row("_____"), p2("ILK", 3));
    tbl[12] = mk(0, "", "N", L_RED, s2row("_____"), p2("ILKN", 4));
    tbl[13] = mk(0, "", "J", L_RED, s2row("_____"), p2("ILKNJ", 5));
    tbl[14] = mk(0, "", "F", L_RED, s2row("YUMMY"), s2row("LOSE"));
    tbl[15] = mk(2, "", 8'h00, L_RED, BLANK, BLANK);

    for (int i = 0; i < 16; i++) begin
      case (tbl[i].kind)
        1:       start_game(tbl[i].word);
        2:       end_game();
        default: do_guess(tbl[i].ch);
      endcase
      chk($sformatf("tbl%0d row1", i), host_row1, tbl[i].r1);
      chk($sformatf("tbl%0d row2", i), host_row2, tbl[i].r2);
      chk($sformatf("tbl%0d leds", i), {124'b0, leds_act}, {124'b0, tbl[i].leds});
    end

    start_game(s2word("MOORE"));
    do_guess(8'h31);
    chk("invalid leds", {124'b0, leds_act}, {124'b0, L_ERR});
    chk("invalid row1", host_row1, s2row("_____"));
    chk("invalid row2", host_row2, p2("", 0));
    repeat (LED_HOLD - 1) @(negedge clk);
    chk("err held", {124'b0, leds_act}, {124'b0, L_ERR});
    @(negedge clk);
    chk("err expired", {124'b0, leds_act}, 128'b0);
    m_leds = 4'b0;

    @(negedge clk); msg = "P"; ready = 1'b1;
    repeat (10) @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    model_guess("P");
    chk("held ready row2", host_row2, p2("P", 1));

    do_guess("Q");
    check_model("two misses");
    @(negedge clk); nRst = 1'b0;
    #1;
    chk("midreset row1", host_row1, BLANK);
    chk("midreset row2", host_row2, BLANK);
    chk("midreset leds", {124'b0, leds_act}, 128'b0);
    @(negedge clk); nRst = 1'b1;
    model_reset();
    start_game(s2word("MOORE"));
    chk("fresh row2", host_row2, p2("", 0));
    check_model("fresh game");
    end_game();

    for (int g = 0; g < 20; g++) begin
      for (int i = 0; i < 5; i++) rw[39-8*i -: 8] = 8'h41 + 8'($urandom_range(0, 7));
      start_game(rw);
      check_model($sformatf("rnd%0d start", g));
      for (int t = 0; t < 30 && m_state == 1; t++) begin
        if ($urandom_range(0, 7) == 0) rc = 8'($urandom_range(0, 63));
        else                           rc = 8'h41 + 8'($urandom_range(0, 9));
        do_guess(rc);
        check_model($sformatf("rnd%0d g%0d", g, t));
      end
      end_game();
      check_model($sformatf("rnd%0d end", g));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
